// File: rtl/template_matcher.sv
`default_nettype none
// ============================================================================
// template_matcher : streaming nearest-template glyph classifier (|p-t| or (p-t)^2)
// Revision 1.0
// ============================================================================
module template_matcher #(
  parameter int PIX_W       = 8,
  parameter int ROWS        = 11,
  parameter int COLS        = 11,
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 24,
  parameter int MODE        = 0,
  localparam int NPIX       = ROWS * COLS,
  localparam int CW         = $clog2(NUM_CLASSES),
  localparam int AW         = $clog2(NPIX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tmpl_we,
  input  logic [CW-1:0]    i_tmpl_class,
  input  logic [AW-1:0]    i_tmpl_addr,
  input  logic [PIX_W-1:0] i_tmpl_data,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  input  logic [PIX_W-1:0] i_pix_data,
  output logic             o_result_valid,
  input  logic             i_result_ready,
  output logic [CW-1:0]    o_result_class,
  output logic [ACC_W-1:0] o_best_dist,
  output logic             o_busy
);

  localparam int DW = (MODE != 0) ? 2 * PIX_W : PIX_W;
  localparam int KW = $clog2(NUM_CLASSES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_ARGMIN = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PIX_W-1:0] r_tmpl    [NUM_CLASSES][NPIX];
  logic [ACC_W-1:0] r_acc     [NUM_CLASSES];
  logic [ACC_W-1:0] w_acc_nxt [NUM_CLASSES];
  logic [AW-1:0]    r_idx;
  logic [KW-1:0]    r_k;
  logic [ACC_W-1:0] r_best;
  logic [CW-1:0]    r_best_cls;
  logic [ACC_W-1:0] w_cand;
  logic             w_xfer;
  logic             w_last;
  logic             w_done;
  logic             w_tmpl_ok;

  assign o_pix_ready    = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign o_result_valid = (r_state == S_RESULT);
  assign o_busy         = (r_state == S_ACCUM) || (r_state == S_ARGMIN);

  assign w_xfer    = i_pix_valid && o_pix_ready;
  assign w_last    = (r_idx == AW'(NPIX - 1));
  assign w_done    = (r_k == KW'(NUM_CLASSES));
  assign w_tmpl_ok = i_tmpl_we && (r_state == S_IDLE) &&
                     (int'(i_tmpl_class) < NUM_CLASSES) && (int'(i_tmpl_addr) < NPIX);

  // Template store is deliberately outside the reset domain so it survives reset.
  always_ff @(posedge clk) begin
    if (w_tmpl_ok) r_tmpl[i_tmpl_class][i_tmpl_addr] <= i_tmpl_data;
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    logic [PIX_W-1:0] w_t;
    logic [PIX_W-1:0] w_ad;
    logic [DW-1:0]    w_d;
    logic [ACC_W:0]   w_sum;

    assign w_t  = r_tmpl[c][r_idx];
    assign w_ad = (i_pix_data >= w_t) ? (i_pix_data - w_t) : (w_t - i_pix_data);

    if (MODE != 0) begin : g_sq
      assign w_d = DW'(w_ad) * DW'(w_ad);
    end else begin : g_abs
      assign w_d = DW'(w_ad);
    end

    // One spare bit on the sum detects overflow for the saturating clamp.
    assign w_sum        = {1'b0, r_acc[c]} + (ACC_W + 1)'(w_d);
    assign w_acc_nxt[c] = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
  end

  always_comb begin
    w_cand = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (r_k == KW'(c)) w_cand = r_acc[c];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer) w_state_nxt = w_last ? S_ARGMIN : S_ACCUM;
      S_ACCUM:  if (w_xfer && w_last) w_state_nxt = S_ARGMIN;
      S_ARGMIN: if (w_done) w_state_nxt = S_RESULT;
      S_RESULT: if (i_result_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_k            <= '0;
      r_best         <= '0;
      r_best_cls     <= '0;
      o_result_class <= '0;
      o_best_dist    <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_idx <= w_last ? '0 : r_idx + AW'(1);
        for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= w_acc_nxt[c];
      end
      if ((r_state == S_RESULT) && i_result_ready) begin
        for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
      end
      // The extra scan step after the last class publishes the winner.
      if (r_state == S_ARGMIN) begin
        if (w_done) begin
          o_result_class <= r_best_cls;
          o_best_dist    <= r_best;
          r_k            <= '0;
        end else begin
          if ((r_k == '0) || (w_cand < r_best)) begin
            r_best     <= w_cand;
            r_best_cls <= CW'(r_k);
          end
          r_k <= r_k + KW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/template_matcher.md
Name: template_matcher

Overview:
- Streaming nearest-template digit classifier for ROWS x COLS grey-level glyphs.
- Accepts one pixel per cycle in raster order.
- Accumulates per-pixel distance against NUM_CLASSES writable templates in parallel, then scans the accumulators for the minimum.
- Reports the winning class and its distance. Sits between the glyph-capture/downscale stage and the game/score logic; replaces fixed per-digit difference arrays with one runtime-loadable, mode-selectable block.

Parameters:
- PIX_W, 8: pixel and template bit width.
- ROWS, 11: glyph rows.
- COLS, 11: glyph columns.
- NUM_CLASSES, 10: number of templates/classes.
- ACC_W, 24: distance accumulator width; accumulation saturates.
- MODE, 0: 0 = absolute difference |p-t|; 1 = squared difference (p-t)^2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tmpl_we  in  1  template write strobe.
- tmpl_class  in  clog2(NUM_CLASSES)  template class to write.
- tmpl_addr  in  clog2(ROWS*COLS)  raster pixel index (row*COLS+col).
- tmpl_data  in  PIX_W  template pixel value.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  block can accept a pixel.
- pix_data  in  PIX_W  input pixel, raster order.
- result_valid  out  1  classification available.
- result_ready  in  1  consumer accepts the result.
- result_class  out  clog2(NUM_CLASSES)  best-matching class.
- best_dist  out  ACC_W  accumulated distance of the best class.
- busy  out  1  high in ACCUM or ARGMIN.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE, pixel index 0, all accumulators 0.
  - pix_ready=1, result_valid=0, result_class=0, best_dist=0, busy=0.
  - Template memory is not cleared.
- Template write:
  - On a clk edge with tmpl_we=1 and state IDLE, tmpl[tmpl_class][tmpl_addr] <= tmpl_data.
  - Writes in any other state are ignored.
  - Out-of-range class/addr values are ignored.
- Pixel transfer: occurs on an edge with pix_valid & pix_ready.
  - pix_ready = 1 in IDLE and ACCUM, 0 in ARGMIN and RESULT.
- Per transfer:
  - For every class c: acc[c] <= sat(acc[c] + d(pix_data, tmpl[c][idx])).
  - d is zero-extended to ACC_W; sat clamps at 2^ACC_W-1.
  - idx increments.
- FSM:
  - IDLE: first transfer -> ACCUM with idx=1. Accumulators were zeroed on entry to IDLE.
  - ACCUM: transfer at idx = ROWS*COLS-1 -> ARGMIN; idx resets to 0. Cycles with pix_valid=0 stall without changing state.
  - ARGMIN: one class per cycle, k = 0..NUM_CLASSES-1.
    - Candidate replaces best only if acc[k] < best (strict), so ties resolve to the lowest class index.
    - After the last class -> RESULT.
  - RESULT: result_valid=1; result_class and best_dist are stable. On result_valid & result_ready -> IDLE, accumulators cleared, result_valid=0 next cycle.
- Latency: result_valid rises exactly NUM_CLASSES+1 edges after the edge accepting the last pixel (11 with defaults).
- Outputs hold their last result values after leaving RESULT until the next RESULT entry.
- Reset mid-frame or mid-scan aborts everything. The next frame starts from pixel 0 and is unaffected.
- Width rules:
  - |p-t| is PIX_W bits.
  - (p-t)^2 is 2*PIX_W bits.
  - ACC_W must be ≥ the distance width. Below the exact sum width, saturation governs.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> outputs immediately pix_ready=1, result_valid=0, result_class=0, best_dist=0, busy=0.
- Basic match (MODE=0):
  - Stimulus: load class 8 = all 100, class 3 = all 50, other classes = all 255; stream 121 pixels of 100.
  - Response: result_class=8, best_dist=0; result_valid high 11 edges after the last pixel.
  - Follow-up: stream all 60 -> class 3, best_dist=1210.
- Tie and stall:
  - Stimulus: classes 2 and 5 identical (all 40), others all 200; stream all 40 with pix_valid toggling every other cycle.
  - Response: result_class=2, best_dist=0; no pixel lost (exactly 121 transfers).
- Squared saturation:
  - Stimulus: MODE=1, ACC_W=16; all templates 0; stream all 255.
  - Response: every acc = 65535; result_class=0, best_dist=65535.
  - Variant: ACC_W=24 -> best_dist = 121*65025 = 7868025.
- Backpressure and write lockout:
  - Stimulus: hold result_ready=0 for 20 cycles; attempt a tmpl_we during RESULT.
  - Response: result_valid and outputs stable, pix_ready=0, template unchanged.
  - Then result_ready=1 for one cycle -> IDLE, pix_ready=1.
- Reset mid-frame:
  - Stimulus: assert reset after 60 pixels of a frame, then stream a full frame matching class 4.
  - Response: result_class=4, best_dist=0; the earlier partial frame has no influence.
